// File: rtl/square_f32_seq.sv
// Sequential binary32 squarer: 24-cycle shift-add over the 24-bit significand,
// then one normalise/round cycle. start/busy/rdy handshake, result held until next start.
module square_f32_seq #(
  localparam int WIDTH         = 32,
  localparam int EXPONENTWIDTH = 8,
  localparam int MANTISSAWIDTH = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             rdy,
  output logic [WIDTH-1:0] sq
);

  localparam int SIGW  = MANTISSAWIDTH + 1;
  localparam int PRODW = 2 * SIGW;

  localparam logic [WIDTH-1:0] SQ_ZERO = 32'h0000_0000;
  localparam logic [WIDTH-1:0] SQ_INF  = 32'h7F80_0000;
  localparam logic [WIDTH-1:0] SQ_NAN  = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t                   r_state;
  logic [SIGW-1:0]          r_mplier;
  logic [PRODW-1:0]         r_mcand;
  logic [PRODW-1:0]         r_acc;
  logic [4:0]               r_cnt;
  logic [EXPONENTWIDTH-1:0] r_ea;
  logic                     r_spec;
  logic [WIDTH-1:0]         r_spec_val;
  logic                     r_busy;
  logic                     r_rdy;
  logic [WIDTH-1:0]         r_sq;

  logic [EXPONENTWIDTH-1:0] w_a_exp;
  logic [MANTISSAWIDTH-1:0] w_a_frac;

  assign w_a_exp  = a[WIDTH-2 -: EXPONENTWIDTH];
  assign w_a_frac = a[MANTISSAWIDTH-1:0];

  // Normalisation and round-to-nearest-even of the finished product.
  logic                     w_g;
  logic                     w_s;
  logic                     w_inc;
  logic [MANTISSAWIDTH-1:0] w_mant;
  logic [MANTISSAWIDTH:0]   w_mant_rnd;
  logic signed [9:0]        w_e;
  logic signed [9:0]        w_e_adj;
  logic [WIDTH-1:0]         w_norm_sq;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_mant    = '0;
    w_g       = 1'b0;
    w_s       = 1'b0;
    w_e       = '0;
    w_norm_sq = SQ_ZERO;
    if (r_acc[PRODW-1]) begin
      w_mant = r_acc[PRODW-2 -: MANTISSAWIDTH];
      w_g    = r_acc[23];
      w_s    = |r_acc[22:0];
      w_e    = $signed({1'b0, r_ea, 1'b0}) - 10'sd126;
    end else begin
      w_mant = r_acc[PRODW-3 -: MANTISSAWIDTH];
      w_g    = r_acc[22];
      w_s    = |r_acc[21:0];
      w_e    = $signed({1'b0, r_ea, 1'b0}) - 10'sd127;
    end
    w_inc      = w_g & (w_s | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + {{MANTISSAWIDTH{1'b0}}, w_inc};
    w_e_adj    = w_mant_rnd[MANTISSAWIDTH] ? w_e + 10'sd1 : w_e;
    if (w_e_adj >= 10'sd255)
      w_norm_sq = SQ_INF;
    else if (w_e_adj <= 10'sd0)
      w_norm_sq = SQ_ZERO;
    else
      w_norm_sq = {1'b0, w_e_adj[EXPONENTWIDTH-1:0], w_mant_rnd[MANTISSAWIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b0;
      r_sq       <= SQ_ZERO;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_ea       <= '0;
      r_spec     <= 1'b0;
      r_spec_val <= SQ_ZERO;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_ea     <= w_a_exp;
            r_mcand  <= {{SIGW{1'b0}}, 1'b1, w_a_frac};
            r_mplier <= {1'b1, w_a_frac};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_rdy    <= 1'b0;
            // Zero/denormal, inf and NaN skip the multiply and resolve on the next edge.
            if (w_a_exp == '0) begin
              r_spec     <= 1'b1;
              r_spec_val <= SQ_ZERO;
              r_state    <= NORM;
            end else if (w_a_exp == '1) begin
              r_spec     <= 1'b1;
              r_spec_val <= (w_a_frac == '0) ? SQ_INF : SQ_NAN;
              r_state    <= NORM;
            end else begin
              r_spec     <= 1'b0;
              r_state    <= MULT;
            end
          end
        end
        MULT: begin
          if (r_mplier[0])
            r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd23)
            r_state <= NORM;
        end
        NORM: begin
          r_sq    <= r_spec ? r_spec_val : w_norm_sq;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign rdy  = r_rdy;
  assign sq   = r_sq;

endmodule
